// File: rtl/vend_seq_ctrl.sv
// vend_seq_ctrl: four-product vending controller with coin credit, dispense handshake and coin-by-coin change return
module vend_seq_ctrl #(
  parameter int PRICE      = 4,
  parameter int MAX_CREDIT = 9,
  parameter int STOCK_INIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  output logic       coin_ready,
  output logic       coin_reject,
  input  logic       sel_valid,
  input  logic [1:0] sel_id,
  output logic       sel_err,
  input  logic       cancel,
  input  logic       restock,
  output logic       disp_req,
  output logic [1:0] disp_id,
  input  logic       disp_done,
  output logic       chg_req,
  input  logic       chg_ack,
  output logic [3:0] credit,
  output logic [3:0] sold_out,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;
  state_t     state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic [3:0] stock_q [4];
  logic [3:0] stock_d [4];
  logic [1:0] disp_id_q, disp_id_d;
  logic       coin_reject_q, coin_reject_d, sel_err_q, sel_err_d;
  logic [4:0] sum;
  logic       coin_ok, sel_ok;
  assign coin_ready  = (state_q == IDLE) && !sel_valid && !cancel && !restock;
  assign sum         = {1'b0, credit_q} + {3'b0, coin_val};
  assign coin_ok     = coin_ready && (coin_val == 2'd1 || coin_val == 2'd2) && sum <= 5'(MAX_CREDIT);
  assign sel_ok      = credit_q >= 4'(PRICE) && stock_q[sel_id] != 4'd0;
  assign coin_reject = coin_reject_q;
  assign sel_err     = sel_err_q;
  assign disp_req    = state_q == DISPENSE;
  assign chg_req     = state_q == CHANGE;
  assign busy        = state_q != IDLE;
  assign disp_id     = disp_id_q;
  assign credit      = credit_q;
  always_comb
    for (int i = 0; i < 4; i++) sold_out[i] = stock_q[i] == 4'd0;
  // restock and cancel claim the cycle even when they have nothing to do
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    stock_d       = stock_q;
    disp_id_d     = disp_id_q;
    coin_reject_d = coin_valid && !coin_ok;
    sel_err_d     = 1'b0;
    case (state_q)
      IDLE:
        if (restock)
          for (int i = 0; i < 4; i++) stock_d[i] = 4'(STOCK_INIT);
        else if (cancel)
          state_d = credit_q != 4'd0 ? CHANGE : IDLE;
        else if (sel_valid) begin
          if (sel_ok) begin
            credit_d        = credit_q - 4'(PRICE);
            stock_d[sel_id] = stock_q[sel_id] - 4'd1;
            disp_id_d       = sel_id;
            state_d         = DISPENSE;
          end else
            sel_err_d = 1'b1;
        end else if (coin_ok)
          credit_d = sum[3:0];
      DISPENSE:
        if (disp_done) state_d = credit_q != 4'd0 ? CHANGE : IDLE;
      CHANGE:
        if (chg_ack) begin
          credit_d = credit_q != 4'd0 ? credit_q - 4'd1 : 4'd0;
          state_d  = credit_q <= 4'd1 ? IDLE : CHANGE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= 4'd0;
      for (int i = 0; i < 4; i++) stock_q[i] <= 4'(STOCK_INIT);
      disp_id_q     <= 2'd0;
      coin_reject_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      stock_q       <= stock_d;
      disp_id_q     <= disp_id_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q     <= sel_err_d;
    end
endmodule

// File: doc/vend_seq_ctrl.md
VEND_SEQ_CTRL -- requirements
Module: vend_seq_ctrl

Interface
REQ-001 SHALL have parameter PRICE, default 4, price in credit units, same for all four products.
REQ-002 SHALL have parameter MAX_CREDIT, default 9, highest credit value allowed (fits 4 bits).
REQ-003 SHALL have parameter STOCK_INIT, default 3, items per product after reset or restock (fits 4 bits).
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port coin_valid  input  1  a coin is offered this cycle.
REQ-007 SHALL have port coin_val  input  2  coin value in units; only 1 and 2 are legal.
REQ-008 SHALL have port coin_ready  output  1  combinational: high when state is IDLE and sel_valid, cancel and restock are all low.
REQ-009 SHALL have port coin_reject  output  1  registered one-cycle pulse: an offered coin was refused.
REQ-010 SHALL have port sel_valid  input  1  product selection strobe; sel_id is the product index.
REQ-011 SHALL have port sel_id  input  2  product index 0..3.
REQ-012 SHALL have port sel_err  output  1  registered one-cycle pulse: a selection was refused.
REQ-013 SHALL have port cancel  input  1  request to return all credit.
REQ-014 SHALL have port restock  input  1  reload all stock counters.
REQ-015 SHALL have port disp_req  output  1  dispense request to the mechanism; disp_id is the product to drop.
REQ-016 SHALL have port disp_id  output  2  product being dispensed.
REQ-017 SHALL have port disp_done  input  1  the mechanism has finished dispensing.
REQ-018 SHALL have port chg_req  output  1  request the hopper to release one 1-unit coin.
REQ-019 SHALL have port chg_ack  input  1  the hopper has released one coin.
REQ-020 SHALL have port credit  output  4  current credit, registered.
REQ-021 SHALL have port sold_out  output  4  bit i is high when stock[i] is 0.
REQ-022 SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-023 SHALL implement three states, IDLE, DISPENSE and CHANGE; coins and selections are honoured only in IDLE.
REQ-024 SHALL accept a coin in IDLE when coin_valid and coin_ready are high, coin_val is 1 or 2, and credit+coin_val <= MAX_CREDIT; credit then equals old credit + coin_val on the next cycle.
REQ-025 SHALL refuse an offered coin, pulse coin_reject next cycle and leave credit unchanged when the coin is illegal (value 0 or 3), would overflow MAX_CREDIT, or coin_ready is low.
REQ-026 SHALL apply this priority in IDLE, highest first: restock > cancel > sel_valid > coin.
REQ-027 SHALL, on restock in IDLE, set all four stock counters to STOCK_INIT and leave credit unchanged; restock outside IDLE is ignored.
REQ-028 SHALL, on cancel in IDLE with credit > 0, move to CHANGE; cancel with credit = 0, or cancel outside IDLE, is ignored.
REQ-029 SHALL, on sel_valid in IDLE with credit >= PRICE and stock[sel_id] > 0, on the next cycle: subtract PRICE from credit, decrement stock[sel_id], latch disp_id = sel_id, and move to DISPENSE.
REQ-030 SHALL, on sel_valid in IDLE with credit < PRICE or stock[sel_id] = 0, pulse sel_err on the next cycle and change no other state.
REQ-031 SHALL hold disp_req high and disp_id stable for the whole of DISPENSE.
REQ-032 SHALL, on disp_done in DISPENSE, drop disp_req on the next cycle and move to CHANGE if credit > 0, else to IDLE.
REQ-033 SHALL hold chg_req high for the whole of CHANGE.
REQ-034 SHALL decrement credit by 1 on each cycle in CHANGE in which chg_ack is high.
REQ-035 SHALL, on chg_ack in CHANGE with credit = 1, reach credit 0 and return to IDLE with chg_req low on the next cycle.
REQ-036 SHALL ignore disp_done outside DISPENSE and chg_ack outside CHANGE.
REQ-037 SHALL never let credit go below 0 or above MAX_CREDIT, and never let a stock counter go below 0 (no wrap-around).

Reset
REQ-038 SHALL, while rst is high, on the next clock edge force state to IDLE, credit to 0, all stock counters to STOCK_INIT, disp_id to 0, and disp_req, chg_req, coin_reject, sel_err and busy to 0.
REQ-039 SHALL abandon any operation in progress (DISPENSE or CHANGE) on reset, with no return of the remaining credit.

Verification
REQ-040 SHALL cover: coins 2, 2, then sel_id=1 -> credit 0, disp_req=1 with disp_id=1; after disp_done -> IDLE with no chg_req.
REQ-041 SHALL cover: coins 2, 2, 1, then sel_id=0, then disp_done -> chg_req=1; one chg_ack -> credit 0, IDLE.
REQ-042 SHALL cover: coin 2 then cancel -> CHANGE; two chg_ack -> credit 0, IDLE.
REQ-043 SHALL cover: three sales of product 2 -> sold_out[2]=1; a fourth sel_id=2 with credit 4 -> sel_err pulse, credit stays 4; restock -> sold_out=0.
REQ-044 SHALL cover: credit 8 and coin_val=2 -> coin_reject pulse, credit stays 8; coin_val=3 -> coin_reject pulse; coin_val=1 -> credit 9.
REQ-045 SHALL cover: rst asserted during DISPENSE -> next cycle disp_req=0, credit=0, busy=0, all stock=STOCK_INIT.
